// File: rtl/dip_led_pkg.sv
// Shared types and constants for the DIP-to-LED display controller.
// The PWM width is only consumed when DIP_LED_PWM_EN is defined.
package dip_led_pkg;

    typedef enum logic [1:0] {
        MODE_MIRROR = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    localparam int PWM_W = 4;

endpackage

// File: rtl/dip_debounce.sv
// One switch bit: 2-FF synchroniser followed by a consecutive-stable-cycle debouncer.
// 'changed' is high in the first cycle that 'dout' shows a newly accepted value.
module dip_debounce #(
    parameter int DEB_CNT = 240000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic changed
);

    localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          changed_q, changed_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any agreement between synchronised input and accepted state restarts the count.
    always_comb begin
        sync1_d   = din;
        sync2_d   = sync1_q;
        stable_d  = stable_q;
        changed_d = 1'b0;
        cnt_d     = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DEB_CNT - 1)) begin
                stable_d  = sync2_q;
                changed_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign dout    = stable_q;
    assign changed = changed_q;

endmodule

// File: rtl/dip_led_ctrl.sv
// Debounced DIP switches driving LEDs in mirror / blink / chase / count modes.
// Define DIP_LED_PWM_EN to add a duty_in brightness input gating lit LEDs.
module dip_led_ctrl
    import dip_led_pkg::*;
#(
    parameter int N_DIPS         = 4,
    parameter int N_LEDS         = 8,
    parameter int DEB_CNT        = 240000,
    parameter int TICK_DIV       = 6000000,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_DIPS-1:0] dips_in,
    input  logic [1:0]        mode_in,
`ifdef DIP_LED_PWM_EN
    input  logic [PWM_W-1:0]  duty_in,
`endif
    output logic [N_LEDS-1:0] leds_out,
    output logic [N_DIPS-1:0] dips_stable,
    output logic              dips_changed
);

    typedef logic [N_LEDS-1:0] led_t;

    localparam int   TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int   IW       = $clog2(N_LEDS);
    localparam led_t LEDS_OFF = (LED_ACTIVE_LOW != 0) ? {N_LEDS{1'b1}} : {N_LEDS{1'b0}};

    logic [N_DIPS-1:0] stable_w;
    logic [N_DIPS-1:0] changed_w;

    for (genvar i = 0; i < N_DIPS; i++) begin : g_deb
        dip_debounce #(
            .DEB_CNT (DEB_CNT)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .din     (dips_in[i]),
            .dout    (stable_w[i]),
            .changed (changed_w[i])
        );
    end

    assign dips_stable  = stable_w;
    assign dips_changed = |changed_w;

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    mode_e         mode_q, mode_d;
    logic          mode_change;
    logic          phase_q, phase_d;
    logic [IW-1:0] chase_idx_q, chase_idx_d;
    led_t          count_q, count_d;
    led_t          leds_q, leds_d;
    led_t          dips_ext;
    led_t          pattern;
    led_t          lit;
`ifdef DIP_LED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
`endif

    assign dips_ext    = led_t'(stable_w);
    assign tick        = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign mode_change = (mode_e'(mode_in) != mode_q);

    // A mode switch re-seeds the pattern and takes priority over a coincident tick.
    always_comb begin
        tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
        mode_d      = mode_e'(mode_in);
        phase_d     = phase_q;
        chase_idx_d = chase_idx_q;
        count_d     = count_q;
        if (mode_change) begin
            phase_d     = 1'b1;
            chase_idx_d = '0;
            count_d     = '0;
        end else if (tick) begin
            case (mode_q)
                MODE_BLINK: phase_d = ~phase_q;
                MODE_CHASE: begin
                    if (stable_w[0]) begin
                        chase_idx_d = (chase_idx_q == '0) ? IW'(N_LEDS - 1) : chase_idx_q - 1'b1;
                    end else begin
                        chase_idx_d = (chase_idx_q == IW'(N_LEDS - 1)) ? '0 : chase_idx_q + 1'b1;
                    end
                end
                MODE_COUNT: count_d = count_q + dips_ext;
                default: ;
            endcase
        end
    end

    always_comb begin
        pattern = '0;
        case (mode_q)
            MODE_MIRROR: pattern = dips_ext;
            MODE_BLINK:  pattern = dips_ext & {N_LEDS{phase_q}};
            MODE_CHASE:  pattern = led_t'(1) << chase_idx_q;
            MODE_COUNT:  pattern = count_q;
            default:     pattern = '0;
        endcase
    end

`ifdef DIP_LED_PWM_EN
    assign pwm_cnt_d = pwm_cnt_q + 1'b1;
    assign lit       = (pwm_cnt_q < duty_in) ? pattern : '0;
`else
    assign lit       = pattern;
`endif

    assign leds_d = (LED_ACTIVE_LOW != 0) ? ~lit : lit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q  <= '0;
            mode_q      <= MODE_MIRROR;
            phase_q     <= 1'b0;
            chase_idx_q <= '0;
            count_q     <= '0;
            leds_q      <= LEDS_OFF;
`ifdef DIP_LED_PWM_EN
            pwm_cnt_q   <= '0;
`endif
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            mode_q      <= mode_d;
            phase_q     <= phase_d;
            chase_idx_q <= chase_idx_d;
            count_q     <= count_d;
            leds_q      <= leds_d;
`ifdef DIP_LED_PWM_EN
            pwm_cnt_q   <= pwm_cnt_d;
`endif
        end
    end

    assign leds_out = leds_q;

endmodule

// File: tb/tb_dip_led_ctrl.sv
// Self-checking bench for dip_led_ctrl against a behavioural model of the display rules.
// Exercises the duty_in path as well when DIP_LED_PWM_EN is defined.
module tb_dip_led_ctrl;

    localparam int N_DIPS         = 4;
    localparam int N_LEDS         = 8;
    localparam int DEB_CNT        = 4;
    localparam int TICK_DIV       = 8;
    localparam int LED_ACTIVE_LOW = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] dips_in = 4'd0;
    logic [1:0] mode_in = 2'd0;
    logic [7:0] leds_out;
    logic [3:0] dips_stable;
    logic       dips_changed;
`ifdef DIP_LED_PWM_EN
    logic [3:0] duty_in = 4'd15;
`endif

    always #5 clk = ~clk;

    dip_led_ctrl #(
        .N_DIPS         (N_DIPS),
        .N_LEDS         (N_LEDS),
        .DEB_CNT        (DEB_CNT),
        .TICK_DIV       (TICK_DIV),
        .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dips_in      (dips_in),
        .mode_in      (mode_in),
`ifdef DIP_LED_PWM_EN
        .duty_in      (duty_in),
`endif
        .leds_out     (leds_out),
        .dips_stable  (dips_stable),
        .dips_changed (dips_changed)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference state: accepted switch value, per-bit run of disagreeing samples,
    // pin history for the two-stage synchroniser, and the display pattern state.
    logic [3:0] m_stable;
    int         m_run[4];
    logic [3:0] m_hist[$];
    logic       m_changed;
    logic [7:0] m_leds;
    int         m_n;
    logic [1:0] m_mode;
    logic       m_phase;
    int         m_pos;
    logic [7:0] m_cnt;

    task automatic modelReset();
        m_stable  = 4'd0;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
        m_hist.delete();
        m_hist.push_back(4'd0);
        m_hist.push_back(4'd0);
        m_changed = 1'b0;
        m_leds    = 8'hFF;
        m_n       = 0;
        m_mode    = 2'd0;
        m_phase   = 1'b0;
        m_pos     = 0;
        m_cnt     = 8'd0;
    endtask

    task automatic modelEdge();
        logic [7:0] p;
        logic [3:0] syncv;
        m_n++;
        case (m_mode)
            2'd0:    p = {4'b0000, m_stable};
            2'd1:    p = m_phase ? {4'b0000, m_stable} : 8'd0;
            2'd2:    p = 8'(1) << m_pos;
            default: p = m_cnt;
        endcase
`ifdef DIP_LED_PWM_EN
        if (((m_n - 1) % 16) >= int'(duty_in)) p = 8'd0;
`endif
        m_leds = ~p;
        if (mode_in != m_mode) begin
            m_mode  = mode_in;
            m_phase = 1'b1;
            m_pos   = 0;
            m_cnt   = 8'd0;
        end else if (m_n % TICK_DIV == 0) begin
            case (m_mode)
                2'd1: m_phase = ~m_phase;
                2'd2: m_pos = m_stable[0] ? (m_pos + N_LEDS - 1) % N_LEDS : (m_pos + 1) % N_LEDS;
                2'd3: m_cnt = m_cnt + {4'b0000, m_stable};
                default: ;
            endcase
        end
        syncv = m_hist.pop_front();
        m_hist.push_back(dips_in);
        m_changed = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (syncv[b] != m_stable[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB_CNT) begin
                    m_stable[b] = syncv[b];
                    m_run[b]    = 0;
                    m_changed   = 1'b1;
                end
            end else begin
                m_run[b] = 0;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] dips, input logic [1:0] mode);
        dips_in = dips;
        mode_in = mode;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput("leds_out", 32'(leds_out), 32'(m_leds));
        checkOutput("dips_stable", 32'(dips_stable), 32'(m_stable));
        checkOutput("dips_changed", 32'(dips_changed), 32'(m_changed));
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic doReset();
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkOutput("rst_async_leds", 32'(leds_out), 32'h0000_00FF);
        checkOutput("rst_async_stable", 32'(dips_stable), 32'h0);
        checkOutput("rst_async_changed", 32'(dips_changed), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_hold_leds", 32'(leds_out), 32'h0000_00FF);
    endtask

    initial begin
        int hold;
        modelReset();
        #1;
        doReset();

        $display("[TB] mirror mode: debounce latency and glitch rejection");
        applyStimulus(4'b0101, 2'd0);
        runCycles(5);
        checkOutput("deb_not_yet", 32'(dips_stable), 32'h0);
        stepCycle();
        checkOutput("deb_accept", 32'(dips_stable), 32'h5);
        checkOutput("deb_pulse", 32'(dips_changed), 32'h1);
        stepCycle();
        checkOutput("mirror_leds", 32'(leds_out), 32'h0000_00FA);
        checkOutput("deb_pulse_end", 32'(dips_changed), 32'h0);
        applyStimulus(4'b0111, 2'd0);
        runCycles(3);
        applyStimulus(4'b0101, 2'd0);
        runCycles(10);
        checkOutput("glitch_reject", 32'(dips_stable), 32'h5);

        $display("[TB] asynchronous reset mid-run");
        doReset();
        applyStimulus(4'b0011, 2'd0);
        runCycles(8);

        $display("[TB] blink mode");
        applyStimulus(4'b0011, 2'd1);
        runCycles(2);
        checkOutput("blink_entry_lit", 32'(leds_out), 32'h0000_00FC);
        runCycles(40);

        $display("[TB] chase mode both directions");
        applyStimulus(4'b0010, 2'd1);
        runCycles(8);
        applyStimulus(4'b0010, 2'd2);
        runCycles(80);
        applyStimulus(4'b0011, 2'd2);
        runCycles(80);

        $display("[TB] count mode with wrap, hold and re-entry");
        applyStimulus(4'b0010, 2'd2);
        runCycles(8);
        applyStimulus(4'b0010, 2'd3);
        runCycles(1100);
        applyStimulus(4'b0000, 2'd3);
        runCycles(40);
        applyStimulus(4'b0010, 2'd3);
        runCycles(60);
        applyStimulus(4'b0010, 2'd0);
        runCycles(3);
        applyStimulus(4'b0010, 2'd3);
        runCycles(40);

`ifdef DIP_LED_PWM_EN
        $display("[TB] pwm brightness");
        duty_in = 4'd4;
        applyStimulus(4'b1111, 2'd0);
        runCycles(64);
        duty_in = 4'd0;
        runCycles(32);
        checkOutput("pwm_dark", 32'(leds_out), 32'h0000_00FF);
        duty_in = 4'd15;
`endif

        $display("[TB] randomized traffic");
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                dips_in = 4'($urandom);
                hold    = int'($urandom_range(1, 12));
            end
            hold--;
            if ($urandom_range(0, 59) == 0) mode_in = 2'($urandom);
`ifdef DIP_LED_PWM_EN
            if ($urandom_range(0, 99) == 0) duty_in = 4'($urandom);
`endif
            stepCycle();
            if (i == 1500) doReset();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
